ibex_ascon_unit: RTL and testbench
==================================

IBEX_ASCON_UNIT -- requirements
Module: ibex_ascon_unit

Interface
REQ-001 SHALL have parameter: EnableXor, 1'b1, when 1'b0 the XOR op is illegal and returns an error.
REQ-002 SHALL have port: clk_i  input  1  core clock.
REQ-003 SHALL have port: rst_ni  input  1  reset; one clock; asynchronous, active-low.
REQ-004 SHALL have port: req_i  input  1  request from ID/EX for an OPCODE_ASCON instruction.
REQ-005 SHALL have port: op_i  input  2  operation: 00 WRITE, 01 READ, 10 PERMUTE, 11 XOR.
REQ-006 SHALL have port: operand_a_i  input  32  write/XOR data; PERMUTE round count in [3:0].
REQ-007 SHALL have port: operand_b_i  input  32  state word index in [3:0]; upper bits ignored.
REQ-008 SHALL have port: kill_i  input  1  pipeline flush; aborts any in-flight op.
REQ-009 SHALL have port: ready_o  output  1  unit can accept a request this cycle.
REQ-010 SHALL have port: valid_o  output  1  single-cycle completion pulse.
REQ-011 SHALL have port: err_o  output  1  completion is an error; qualified by valid_o.
REQ-012 SHALL have port: result_o  output  32  READ data; qualified by valid_o.

Function
REQ-013 SHALL hold a 320-bit state as five 64-bit lanes x0..x4; word 2k = xk[31:0], word 2k+1 = xk[63:32]; indices 0..9.
REQ-014 SHALL accept a request on the clk_i edge where req_i && ready_o && !kill_i.
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE; ready_o = 1 only in IDLE.
REQ-016 SHALL, on acceptance, latch op, index, data and round count.
REQ-017 SHALL, for WRITE: set word[idx] = operand_a_i; go IDLE->DONE.
REQ-018 SHALL, for XOR: set word[idx] ^= operand_a_i; go IDLE->DONE.
REQ-019 SHALL, for READ: capture word[idx] into result register; go IDLE->DONE.
REQ-020 SHALL flag an error for: idx > 9 (WRITE/READ/XOR); PERMUTE count N = 0 or N > 12; XOR when EnableXor = 0.
REQ-021 SHALL, on an error: leave state unchanged, go IDLE->DONE and set err_o = 1 in DONE.
REQ-022 SHALL, for a legal PERMUTE N: go IDLE->BUSY and apply exactly one round per cycle for N cycles, then go to DONE.
REQ-023 SHALL, for PERMUTE N, use round constants r = 12-N .. 11, with constant c = {4'(15-r), 4'(r)} XORed into x2[7:0].
REQ-024 SHALL implement each round per the Ascon spec: constant addition, 5-bit bitsliced S-box, then linear layer:
- x0 ^= ror19 ^ ror28
- x1 ^= ror61 ^ ror39
- x2 ^= ror1 ^ ror6
- x3 ^= ror10 ^ ror17
- x4 ^= ror7 ^ ror41
REQ-025 SHALL assert valid_o for exactly one cycle in DONE, then go DONE->IDLE.
REQ-026 SHALL drive result_o with the READ data when valid_o is high for a READ, and 0 otherwise.
REQ-027 SHALL give latency from the acceptance edge to valid_o high: WRITE/READ/XOR/error = 1 cycle; PERMUTE N = N+1 cycles.
REQ-028 SHALL, when kill_i = 1 in BUSY or DONE: go to IDLE next cycle; valid_o is suppressed that cycle; partially permuted state is retained.
REQ-029 SHALL ignore req_i while not in IDLE; no queuing.

Reset
REQ-030 SHALL, on rst_ni low, asynchronously clear the state to all zeros, FSM to IDLE, ready_o = 1, valid_o = 0, err_o = 0, result_o = 0.
REQ-031 SHALL, on reset asserted mid-PERMUTE, abort the operation with no valid_o pulse.

Verification
REQ-032 SHALL cover: WRITE idx 3 with 0xDEADBEEF, then READ idx 3 -> valid_o 1 cycle after each acceptance; result_o = 0xDEADBEEF; err_o = 0.
REQ-033 SHALL cover: READ idx 10 -> valid_o = 1, err_o = 1, result_o = 0; state unchanged.
REQ-034 SHALL cover: PERMUTE N = 12 on the all-zero state -> ready_o low for 13 cycles; valid_o in cycle 13; all 10 words match the golden Ascon-p[12] model.
REQ-035 SHALL cover: PERMUTE N = 13, then N = 0 -> each gives valid_o + err_o after 1 cycle; state unchanged.
REQ-036 SHALL cover: PERMUTE N = 6 with kill_i at cycle 3 -> no valid_o; ready_o = 1 next cycle; state equals golden after 2 rounds (r = 6, 7).
REQ-037 SHALL cover: rst_ni low during BUSY -> outputs reset immediately (asynchronously); state reads back 0 after release.

Source files
------------

// File: rtl/ibex_ascon_unit.sv
// Ascon-p coprocessor unit: 320-bit state addressed as ten 32-bit words,
// with WRITE/READ/XOR word access and a one-round-per-cycle PERMUTE.
module ibex_ascon_unit #(
    parameter bit EnableXor = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic        kill_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic        err_o,
    output logic [31:0] result_o
);

    localparam logic [1:0] OP_WRITE   = 2'b00;
    localparam logic [1:0] OP_READ    = 2'b01;
    localparam logic [1:0] OP_PERMUTE = 2'b10;
    localparam logic [1:0] OP_XOR     = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [4:0][63:0]  x_q;
    logic [3:0]        round_q;
    logic              err_q;
    logic [31:0]       result_q;

    logic              accept;
    logic              req_err;
    logic [3:0]        idx;
    logic [3:0]        num_rounds;
    logic [2:0]        lane;
    logic [63:0]       lane_val;
    logic [31:0]       word_rd;
    logic [31:0]       word_new;
    logic [63:0]       lane_new;
    logic              unused_idx_hi;

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // One Ascon-p round: constant addition, bitsliced S-box, linear layer.
    function automatic logic [4:0][63:0] ascon_round(input logic [4:0][63:0] s,
                                                     input logic [3:0]       r);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[0];
        x1 = s[1];
        x2 = s[2] ^ {56'd0, 4'd15 - r, r};
        x3 = s[3];
        x4 = s[4];
        x0 ^= x4;
        x4 ^= x3;
        x2 ^= x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 ^= t1;
        x1 ^= t2;
        x2 ^= t3;
        x3 ^= t4;
        x4 ^= t0;
        x1 ^= x0;
        x0 ^= x4;
        x3 ^= x2;
        x2 = ~x2;
        x0 ^= rotr(x0, 19) ^ rotr(x0, 28);
        x1 ^= rotr(x1, 61) ^ rotr(x1, 39);
        x2 ^= rotr(x2, 1)  ^ rotr(x2, 6);
        x3 ^= rotr(x3, 10) ^ rotr(x3, 17);
        x4 ^= rotr(x4, 7)  ^ rotr(x4, 41);
        return {x4, x3, x2, x1, x0};
    endfunction

    assign idx           = operand_b_i[3:0];
    assign num_rounds    = operand_a_i[3:0];
    assign lane          = idx[3:1];
    assign unused_idx_hi = ^operand_b_i[31:4];
    assign accept        = req_i && (state_q == IDLE) && !kill_i;

    always_comb begin
        lane_val = 64'd0;
        if (lane <= 3'd4) begin
            lane_val = x_q[lane];
        end
    end

    assign word_rd  = idx[0] ? lane_val[63:32] : lane_val[31:0];
    assign word_new = (op_i == OP_XOR) ? (word_rd ^ operand_a_i) : operand_a_i;
    assign lane_new = idx[0] ? {word_new, lane_val[31:0]} : {lane_val[63:32], word_new};

    always_comb begin
        req_err = 1'b0;
        case (op_i)
            OP_WRITE, OP_READ: req_err = (idx > 4'd9);
            OP_XOR:            req_err = (idx > 4'd9) || !EnableXor;
            OP_PERMUTE:        req_err = (num_rounds == 4'd0) || (num_rounds > 4'd12);
            default:           req_err = 1'b1;
        endcase
    end

    // Word accesses take effect on the acceptance edge; a PERMUTE starts at
    // round 12-N and advances one round per BUSY cycle unless killed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            x_q      <= '0;
            round_q  <= 4'd0;
            err_q    <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                err_q    <= req_err;
                result_q <= 32'd0;
                round_q  <= 4'd12 - num_rounds;
                if (!req_err) begin
                    case (op_i)
                        OP_WRITE, OP_XOR: x_q[lane] <= lane_new;
                        OP_READ:          result_q  <= word_rd;
                        default:          ;
                    endcase
                end
            end else if ((state_q == BUSY) && !kill_i) begin
                x_q     <= ascon_round(x_q, round_q);
                round_q <= round_q + 4'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (accept) begin
                    state_d = ((op_i == OP_PERMUTE) && !req_err) ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (kill_i) begin
                    state_d = IDLE;
                end else if (round_q == 4'd11) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                valid_o = !kill_i;
            end
            default: state_d = IDLE;
        endcase
    end

    assign err_o    = valid_o && err_q;
    assign result_o = valid_o ? result_q : 32'd0;

endmodule

// File: tb/tb_ibex_ascon_unit.sv
// Directed bench for ibex_ascon_unit: a word/lane model with a table-driven
// Ascon S-box predicts every output cycle and every readable state word.
module tb_ibex_ascon_unit;

    localparam logic [1:0] OP_WRITE   = 2'b00;
    localparam logic [1:0] OP_READ    = 2'b01;
    localparam logic [1:0] OP_PERMUTE = 2'b10;
    localparam logic [1:0] OP_XOR     = 2'b11;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        req_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] operand_a_i = 32'd0;
    logic [31:0] operand_b_i = 32'd0;
    logic        kill_i = 1'b0;
    logic        ready_o;
    logic        valid_o;
    logic        err_o;
    logic [31:0] result_o;

    int nVectors = 0;
    int nMiscompares = 0;

    bit          checkEn = 1'b0;
    logic        expReady, expValid, expErr;
    logic [31:0] expResult;

    logic [63:0] mdl [5];

    logic [4:0] sboxTab [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    // One round (r = 0) from the all-zero state, worked out by hand.
    logic [31:0] pinWords [10] = '{
        32'h000000F0, 32'h001E0F00, 32'hE0000770, 32'h00000001, 32'hFFFFFF74,
        32'h3FFFFFFF, 32'h000000F0, 32'h3C780000, 32'h00000000, 32'h00000000
    };

    ibex_ascon_unit #(.EnableXor(1'b1)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .op_i        (op_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .kill_i      (kill_i),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .err_o       (err_o),
        .result_o    (result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %h, wanted %h at %0t", name, act, exp, $time);
        end
    endtask

    always begin
        @(negedge clk_i);
        #2;
        if (checkEn) begin
            checkOutput("ready_o", 32'(ready_o), 32'(expReady));
            checkOutput("valid_o", 32'(valid_o), 32'(expValid));
            checkOutput("err_o", 32'(err_o), 32'(expErr));
            checkOutput("result_o", result_o, expResult);
        end
    end

    function automatic logic [63:0] rotr64(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [31:0] getWord(input int i);
        return i[0] ? mdl[i / 2][63:32] : mdl[i / 2][31:0];
    endfunction

    task automatic setWord(input int i, input logic [31:0] w);
        if (i[0]) mdl[i / 2][63:32] = w;
        else      mdl[i / 2][31:0]  = w;
    endtask

    task automatic mdlRound(input int r);
        logic [63:0] s [5];
        logic [63:0] t [5];
        logic [4:0]  o;
        s = mdl;
        s[2] ^= 64'((15 - r) * 16 + r);
        for (int b = 0; b < 64; b++) begin
            o = sboxTab[{s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]}];
            for (int k = 0; k < 5; k++) t[k][b] = o[4 - k];
        end
        mdl[0] = t[0] ^ rotr64(t[0], 19) ^ rotr64(t[0], 28);
        mdl[1] = t[1] ^ rotr64(t[1], 61) ^ rotr64(t[1], 39);
        mdl[2] = t[2] ^ rotr64(t[2], 1)  ^ rotr64(t[2], 6);
        mdl[3] = t[3] ^ rotr64(t[3], 10) ^ rotr64(t[3], 17);
        mdl[4] = t[4] ^ rotr64(t[4], 7)  ^ rotr64(t[4], 41);
    endtask

    task automatic tick(input logic req, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic kill, input logic eReady,
                        input logic eValid, input logic eErr, input logic [31:0] eRes);
        @(negedge clk_i);
        req_i = req; op_i = op; operand_a_i = a; operand_b_i = b; kill_i = kill;
        expReady = eReady; expValid = eValid; expErr = eErr; expResult = eRes;
        checkEn = 1'b1;
    endtask

    // Issues one request and walks its whole timeline; killAt counts cycles
    // after acceptance (0 = never killed). Busy cycles carry a stray request.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int killAt);
        int idx, n;
        logic err;
        logic [31:0] res;
        bit killed;
        idx = int'(b[3:0]);
        n = int'(a[3:0]);
        err = (op == OP_PERMUTE) ? (n == 0 || n > 12) : (idx > 9);
        res = 32'd0;
        killed = 1'b0;
        tick(1'b1, op, a, b, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        if (op != OP_PERMUTE || err) begin
            if (!err) begin
                case (op)
                    OP_WRITE: setWord(idx, a);
                    OP_XOR:   setWord(idx, getWord(idx) ^ a);
                    default:  res = getWord(idx);
                endcase
            end
            tick(1'b0, OP_WRITE, 32'd0, 32'd0, killAt == 1, 1'b0, killAt != 1,
                 err && (killAt != 1), (killAt != 1) ? res : 32'd0);
        end else begin
            for (int c = 1; c <= n && !killed; c++) begin
                if (killAt == c) begin
                    tick(1'b1, OP_WRITE, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
                    killed = 1'b1;
                end else begin
                    tick(1'b1, OP_WRITE, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
                    mdlRound(12 - n + c - 1);
                end
            end
            if (!killed) begin
                tick(1'b1, OP_WRITE, 32'hFFFFFFFF, 32'd0, killAt == n + 1, 1'b0,
                     killAt != n + 1, 1'b0, 32'd0);
            end
        end
        tick(1'b0, OP_WRITE, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic readAll();
        for (int i = 0; i < 10; i++) applyStimulus(OP_READ, 32'd0, 32'(i), 0);
    endtask

    task automatic zeroAll();
        for (int i = 0; i < 10; i++) applyStimulus(OP_WRITE, 32'd0, 32'(i), 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ready"}, 32'(ready_o), 32'd1);
        checkOutput({tag, "_valid"}, 32'(valid_o), 32'd0);
        checkOutput({tag, "_err"}, 32'(err_o), 32'd0);
        checkOutput({tag, "_result"}, result_o, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 5; i++) mdl[i] = 64'd0;
        #1 rst_ni = 1'b0;
        #1 checkResetOutputs("reset");
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // One round r = 0 on the zero state, pinned to hand-worked words.
        applyStimulus(OP_PERMUTE, 32'd12, 32'd0, 2);
        for (int i = 0; i < 10; i++) checkOutput("pin_model_word", getWord(i), pinWords[i]);
        readAll();

        zeroAll();
        applyStimulus(OP_WRITE, 32'hDEADBEEF, 32'd3, 0);
        applyStimulus(OP_READ, 32'd0, 32'd3, 0);
        applyStimulus(OP_WRITE, 32'hCAFEF00D, 32'h00000013, 0);
        applyStimulus(OP_READ, 32'd0, 32'hFFFFFF03, 0);
        applyStimulus(OP_READ, 32'd0, 32'd10, 0);
        applyStimulus(OP_WRITE, 32'h55555555, 32'd12, 0);
        applyStimulus(OP_XOR, 32'h55555555, 32'd15, 0);
        applyStimulus(OP_WRITE, 32'h12345678, 32'd5, 0);
        applyStimulus(OP_XOR, 32'h0F0F0F0F, 32'd5, 0);
        readAll();

        zeroAll();
        applyStimulus(OP_PERMUTE, 32'd12, 32'd0, 0);
        readAll();

        applyStimulus(OP_PERMUTE, 32'd13, 32'd0, 0);
        applyStimulus(OP_PERMUTE, 32'd0, 32'd0, 0);
        applyStimulus(OP_PERMUTE, 32'h00000010, 32'd0, 0);
        readAll();

        applyStimulus(OP_PERMUTE, 32'd6, 32'd0, 3);
        readAll();

        applyStimulus(OP_PERMUTE, 32'd1, 32'd0, 2);
        readAll();

        // A request alongside kill in IDLE must be dropped.
        tick(1'b1, OP_WRITE, 32'h11111111, 32'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        tick(1'b0, OP_WRITE, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        applyStimulus(OP_READ, 32'd0, 32'd1, 0);

        // Reset asserted mid-permutation, away from the clock edge.
        tick(1'b1, OP_PERMUTE, 32'd12, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        repeat (4) tick(1'b0, OP_WRITE, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        checkEn = 1'b0;
        @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1 checkResetOutputs("async_reset");
        repeat (2) @(negedge clk_i);
        checkResetOutputs("held_reset");
        rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) mdl[i] = 64'd0;
        readAll();

        @(negedge clk_i);
        checkEn = 1'b0;
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
